// File: rtl/mul_final_adder.sv
// Slice-serial carry-propagate adder that resolves the compressor tree's sum/carry pair.
// Ports: in_valid_i/in_ready_o/sum_vec_i/cary_vec_i in; out_valid_o/out_ready_i/result_o/cout_o out; busy_o.
module mul_final_adder #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] sum_vec_i,
  input  logic [WIDTH-1:0] cary_vec_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             busy_o
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              cout_q, cout_d;

  logic [SLICE-1:0]  a_sl;
  logic [SLICE-1:0]  b_sl;
  logic [SLICE:0]    s_sum;

  assign a_sl  = a_q[idx_q*SLICE +: SLICE];
  assign b_sl  = b_q[idx_q*SLICE +: SLICE];
  assign s_sum = {1'b0, a_sl} + {1'b0, b_sl}
               + {{SLICE{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          a_d     = sum_vec_i;
          b_d     = cary_vec_i;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        res_d[idx_q*SLICE +: SLICE] = s_sum[SLICE-1:0];
        carry_d = s_sum[SLICE];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = s_sum[SLICE];
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

  // Ready is gated by reset so no pair is handed over while it is held.
  assign in_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q == S_ADD) || (state_q == S_DONE);
  assign result_o    = res_q;
  assign cout_o      = cout_q;

endmodule

// File: tb/tb_mul_final_adder.sv
// Bench for mul_final_adder: directed corner cases plus a scoreboarded random run.
// Instantiates the 64/16 configuration and the degenerate 32/32 one.
module tb_mul_final_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] sum, cary;
  logic        out_valid, out_ready;
  logic [63:0] result;
  logic        cout, busy;

  logic        in_valid32, in_ready32;
  logic [31:0] sum32, cary32;
  logic        out_valid32, out_ready32;
  logic [31:0] result32;
  logic        cout32, busy32;

  int total = 0;
  int bad = 0;
  logic [64:0] q[$];

  always #5 clk = ~clk;

  mul_final_adder #(.WIDTH(64), .SLICE(16)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sum_vec_i(sum), .cary_vec_i(cary),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .cout_o(cout), .busy_o(busy)
  );

  mul_final_adder #(.WIDTH(32), .SLICE(32)) u_dut32 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid32), .in_ready_o(in_ready32),
    .sum_vec_i(sum32), .cary_vec_i(cary32),
    .out_valid_o(out_valid32), .out_ready_i(out_ready32),
    .result_o(result32), .cout_o(cout32), .busy_o(busy32)
  );

  task automatic chk(input string tag,
                     input logic [64:0] got,
                     input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [63:0] s,
                        input logic [63:0] c,
                        output int lat);
    @(posedge clk); #1;
    sum = s; cary = c; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("op_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic release_out();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic gen_pair(output logic [63:0] s,
                          output logic [63:0] c);
    logic [31:0] a, b;
    logic [63:0] p;
    a = $urandom; b = $urandom;
    p = {32'h0, a} * {32'h0, b};
    c = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) c = 64'h1;
    s = p - c;
    if ($urandom_range(0, 7) == 0) s = {$urandom, $urandom};
  endtask

  initial begin
    int lat;
    int sent, recv, cyc, seen;
    logic acc;
    logic [63:0] s, c, held;
    logic [64:0] e;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    sum = '0; cary = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0;
    sum32 = '0; cary32 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_gated", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", {cout, result}, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset in the middle of ADD.
    sum = 64'h1234_5678_9ABC_DEF0; cary = 64'h0F0F_0F0F_0F0F_0F0F;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_add_busy", busy, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_result", {cout, result}, 0);
    chk("post_rst_in_ready", in_ready, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post_rst_no_valid", seen, 0);

    // Full ripple across every slice boundary.
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat);
    chk("ripple_lat", lat, 4);
    chk("ripple_res", {cout, result}, {1'b1, 64'h0});
    release_out();

    run_op(64'h0000_0000_0000_FFFF, 64'h1, lat);
    chk("bound_res", {cout, result}, {1'b0, 64'h1_0000});
    release_out();

    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat);
    chk("msb_res", {cout, result}, {1'b1, 64'h0});
    release_out();

    // Backpressure in DONE with a restless producer.
    run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, lat);
    held = 64'h0123_4567_89AB_CDEF + 64'h1111_1111_1111_1111;
    chk("bp_first", {cout, result}, {1'b0, held});
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      sum = {$urandom, $urandom};
      cary = {$urandom, $urandom};
      @(negedge clk);
      if (!out_valid || in_ready || result !== held) seen++;
    end
    chk("bp_stable", seen, 0);
    @(posedge clk); #1;
    sum = 64'hAAAA_0000_5555_FFFF;
    cary = 64'h5555_0000_AAAA_0001;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    @(negedge clk);
    chk("bp_pending_res", {cout, result},
        {1'b0, 64'hAAAA_0000_5555_FFFF} + {1'b0, 64'h5555_0000_AAAA_0001});
    release_out();

    // Degenerate single-slice configuration.
    @(posedge clk); #1;
    sum32 = 32'hFFFF_FFFF; cary32 = 32'h1; in_valid32 = 1'b1;
    @(negedge clk);
    chk("d32_in_ready", in_ready32, 1);
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d32_lat", lat, 1);
    @(negedge clk);
    chk("d32_res", {cout32, result32}, {1'b1, 32'h0});
    @(posedge clk); #1 out_ready32 = 1'b1;
    @(posedge clk); #1 out_ready32 = 1'b0;

    // Random traffic against the scoreboard.
    sent = 0; recv = 0; cyc = 0; acc = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    while (recv < 2000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      acc = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("rand_res", {cout, result}, e);
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back({1'b0, sum} + {1'b0, cary});
        sent++;
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        if (sent < 2000 && $urandom_range(0, 9) < 6) begin
          gen_pair(s, c);
          sum = s; cary = c; in_valid = 1'b1;
        end else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 9) < 7);
    end
    chk("rand_count", recv, 2000);
    chk("rand_leftover", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
